alu_seq_md: RTL and testbench
=============================

# alu_seq_md

Parametrised multi-cycle successor to the single-cycle MIPS ALU. It adds registered outputs, a start/busy/done handshake, SUB/SRA/SLT/SLTU, and an iterative unsigned multiplier and divider feeding HI/LO registers. It sits in the execute stage; the control unit issues one operation per `start` and stalls on `busy`.

## Interface
- `WIDTH`, 32, datapath width in bits; must be even and ≥ 8.
- `SHAMT_W`, 5, shift-amount width; must equal clog2(`WIDTH`).
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request; accepted only on an edge where `busy`=0.
- `ALUOperation` input 4: opcode, sampled with `start`.
- `A` input `WIDTH`: operand A, sampled with `start`.
- `B` input `WIDTH`: operand B, sampled with `start`.
- `shamt` input `SHAMT_W`: shift amount, sampled with `start`.
- `busy` output 1: a multiply or divide iteration is in progress.
- `done` output 1: one-cycle pulse; results valid.
- `ALUResult` output `WIDTH`: registered result.
- `Zero` output 1: registered; high when `ALUResult`==0.
- `Hi` output `WIDTH`: HI register.
- `Lo` output `WIDTH`: LO register.
- `div_by_zero` output 1: registered; flags the last DIVU as having B==0.

## Operation
- Opcodes, all arithmetic modulo 2^`WIDTH` with no overflow flag:
  - 0 AND: A&B.
  - 1 OR: A|B.
  - 2 NOR: ~(A|B).
  - 3 ADD: A+B.
  - 4 SLL: A<<shamt.
  - 5 SRL: A>>shamt, logical.
  - 6 SRA: A>>>shamt, arithmetic.
  - 7 SUB: A−B.
  - 8 LUI: {B[WIDTH/2−1:0], WIDTH/2 zeros}.
  - 9 SLT: signed A<B → 1, else 0.
  - 10 SLTU: unsigned A<B → 1, else 0.
  - 11 MULTU: {Hi,Lo}=A×B, unsigned.
  - 12 DIVU: Lo=A/B, Hi=A%B, unsigned.
  - 13 MFHI: result = Hi.
  - 14 MFLO: result = Lo.
  - 15 reserved: result 0.
- FSM states: IDLE, MUL, DIV.
  - IDLE: on an accepted `start`, opcodes 11 and 12 (B≠0) go to MUL or DIV; every other opcode completes in one cycle and stays in IDLE.
  - MUL: shift-add, one bit per cycle, `WIDTH` iterations, then IDLE.
  - DIV: restoring division, one quotient bit per cycle, `WIDTH` iterations, then IDLE.
- For MULTU and DIVU, `ALUResult` = final Lo.
- `Hi`/`Lo` change only on MULTU/DIVU completion. Intermediate iteration values are never visible on `Hi`/`Lo`.
- `div_by_zero`:
  - Set by DIVU with B==0.
  - Cleared by any other accepted DIVU.
  - Unaffected by other opcodes.
- `start` while `busy`=1 is ignored; operands and opcode are not latched.

## Timing
- Reset:
  - `busy`=0, `done`=0, `ALUResult`=0, `Zero`=1, `Hi`=0, `Lo`=0, `div_by_zero`=0.
  - FSM returns to IDLE.
  - Reset asserted mid-MUL/DIV aborts the operation; no `done` is issued.
- Single-cycle ops, accepted at edge k:
  - `ALUResult`/`Zero` valid and `done`=1 after edge k, i.e. latency 1.
  - `done` drops after edge k+1 unless a new op is accepted at k+1.
- MULTU/DIVU, accepted at edge k:
  - `busy`=1 after edges k … k+`WIDTH`−1.
  - After edge k+`WIDTH`: `busy`=0, `done`=1, and `Hi`/`Lo`/`ALUResult`/`Zero` are valid.
  - Latency is `WIDTH` cycles.
- DIVU with B==0: completes in 1 cycle with Lo = all ones, Hi = A, `div_by_zero`=1. `busy` is never asserted.
- Back-to-back issue:
  - A new `start` may coincide with `done`=1, since `busy` is 0 in that cycle.
  - Single-cycle ops can issue every cycle, giving `done` high continuously.
- MFHI/MFLO issued the cycle `done` is high for a MULTU read the new Hi/Lo.

## Configuration
- `ALU_DIV_EN` defined:
  - DIVU and the DIV state are implemented as above.
- `ALU_DIV_EN` undefined:
  - The divider logic is removed.
  - Opcode 12 behaves as reserved: result 0, 1-cycle `done`, `Hi`/`Lo` unchanged.
  - `div_by_zero` is tied to 0.

## Test plan
- Reset, then ADD with A=0x7FFFFFFF, B=1 → after 1 edge: `ALUResult`=0x80000000, `Zero`=0, `done`=1 for exactly 1 cycle.
- SUB with A=5, B=5 → `ALUResult`=0, `Zero`=1. Then SRA with A=0x80000000, shamt=4 → 0xF8000000. Then SLT with A=0xFFFFFFFF, B=1 → 1. Then SLTU with the same operands → 0.
- MULTU with A=0xFFFFFFFF, B=0xFFFFFFFF → `busy` high exactly 32 cycles; then Hi=0xFFFFFFFE, Lo=0x00000001, `done` pulse. `start` with AND asserted mid-run is ignored, and Hi/Lo stay unchanged until completion.
- DIVU with A=100, B=7 → after 32 cycles: Lo=14, Hi=2. Then DIVU with A=9, B=0 → after 1 edge: Lo=0xFFFFFFFF, Hi=9, `div_by_zero`=1, `busy` never high.
- MULTU with A=3, B=4 completes; MFLO issued in the `done` cycle → `ALUResult`=12. Then MFHI → 0.
- `reset` pulsed at iteration 10 of a DIVU → all outputs return to their reset values, no `done`, and a following ADD with A=1, B=2 gives 3.

Source files
------------

// File: rtl/alu_seq_md.sv
// alu_seq_md: multi-cycle MIPS-style ALU with registered outputs, a
// start/busy/done handshake and an iterative unsigned multiplier/divider
// feeding HI/LO. The divider is built only when ALU_DIV_EN is defined;
// otherwise opcode 12 behaves as a reserved opcode.
module alu_seq_md #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         ALUOperation,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   ALUResult,
  output logic               Zero,
  output logic [WIDTH-1:0]   Hi,
  output logic [WIDTH-1:0]   Lo,
  output logic               div_by_zero
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state_reg, state_next;
  logic [SHAMT_W-1:0] cnt_reg, cnt_next;
  // acc: partial upper product (MUL) or partial remainder (DIV)
  // shreg: multiplier / low product (MUL) or dividend / quotient (DIV)
  // opnd: multiplicand (MUL) or divisor (DIV)
  logic [WIDTH-1:0]   acc_reg, acc_next;
  logic [WIDTH-1:0]   shreg_reg, shreg_next;
  logic [WIDTH-1:0]   opnd_reg, opnd_next;
  logic [WIDTH-1:0]   res_reg, res_next;
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;
  logic               zero_reg, zero_next;
  logic               done_reg, done_next;
`ifdef ALU_DIV_EN
  logic               dbz_reg, dbz_next;
`endif

  logic [WIDTH-1:0]   simple_res;
  logic               last_iter;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_acc, mul_sh;
`ifdef ALU_DIV_EN
  logic [WIDTH:0]     div_r;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub, div_acc, div_sh;
`endif

  assign last_iter = (cnt_reg == SHAMT_W'(WIDTH - 1));

  // Single-cycle opcode results; multi-cycle and reserved opcodes yield 0 here
  always_comb begin
    simple_res = '0;
    case (ALUOperation)
      4'd0:    simple_res = A & B;
      4'd1:    simple_res = A | B;
      4'd2:    simple_res = ~(A | B);
      4'd3:    simple_res = A + B;
      4'd4:    simple_res = A << shamt;
      4'd5:    simple_res = A >> shamt;
      4'd6:    simple_res = $unsigned($signed(A) >>> shamt);
      4'd7:    simple_res = A - B;
      4'd8:    simple_res = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      4'd9:    simple_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'd10:   simple_res = {{(WIDTH-1){1'b0}}, (A < B)};
      4'd13:   simple_res = hi_reg;
      4'd14:   simple_res = lo_reg;
      default: simple_res = '0;
    endcase
  end

  // One shift-add multiply step: add multiplicand if LSB set, then shift the
  // {acc, shreg} pair right by one so the product accumulates in place
  always_comb begin
    mul_sum = {1'b0, acc_reg} + {1'b0, (shreg_reg[0] ? opnd_reg : {WIDTH{1'b0}})};
    mul_acc = mul_sum[WIDTH:1];
    mul_sh  = {mul_sum[0], shreg_reg[WIDTH-1:1]};
  end

`ifdef ALU_DIV_EN
  // One restoring-division step: shift in the next dividend bit, subtract the
  // divisor when it fits; the remainder stays below the divisor so WIDTH bits suffice
  always_comb begin
    div_r   = {acc_reg, shreg_reg[WIDTH-1]};
    div_ge  = (div_r >= {1'b0, opnd_reg});
    div_sub = div_r[WIDTH-1:0] - opnd_reg;
    div_acc = div_ge ? div_sub : div_r[WIDTH-1:0];
    div_sh  = {shreg_reg[WIDTH-2:0], div_ge};
  end
`endif

  // Next-state and datapath control for the IDLE/MUL/DIV sequencer
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    acc_next   = acc_reg;
    shreg_next = shreg_reg;
    opnd_next  = opnd_reg;
    res_next   = res_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    zero_next  = zero_reg;
    done_next  = 1'b0;
`ifdef ALU_DIV_EN
    dbz_next   = dbz_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          case (ALUOperation)
            4'd11: begin
              opnd_next  = A;
              shreg_next = B;
              acc_next   = '0;
              cnt_next   = '0;
              state_next = MUL;
            end
`ifdef ALU_DIV_EN
            4'd12: begin
              if (B == '0) begin
                // Divide by zero finishes at once with a defined result
                lo_next   = '1;
                hi_next   = A;
                res_next  = '1;
                zero_next = 1'b0;
                dbz_next  = 1'b1;
                done_next = 1'b1;
              end else begin
                opnd_next  = B;
                shreg_next = A;
                acc_next   = '0;
                cnt_next   = '0;
                dbz_next   = 1'b0;
                state_next = DIV;
              end
            end
`endif
            default: begin
              res_next  = simple_res;
              zero_next = (simple_res == '0);
              done_next = 1'b1;
            end
          endcase
        end
      end
      MUL: begin
        acc_next   = mul_acc;
        shreg_next = mul_sh;
        cnt_next   = cnt_reg + 1'b1;
        if (last_iter) begin
          hi_next    = mul_acc;
          lo_next    = mul_sh;
          res_next   = mul_sh;
          zero_next  = (mul_sh == '0);
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      DIV: begin
`ifdef ALU_DIV_EN
        acc_next   = div_acc;
        shreg_next = div_sh;
        cnt_next   = cnt_reg + 1'b1;
        if (last_iter) begin
          hi_next    = div_acc;
          lo_next    = div_sh;
          res_next   = div_sh;
          zero_next  = (div_sh == '0);
          done_next  = 1'b1;
          state_next = IDLE;
        end
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset aborts any iteration in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      shreg_reg <= '0;
      opnd_reg  <= '0;
      res_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      zero_reg  <= 1'b1;
      done_reg  <= 1'b0;
`ifdef ALU_DIV_EN
      dbz_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      acc_reg   <= acc_next;
      shreg_reg <= shreg_next;
      opnd_reg  <= opnd_next;
      res_reg   <= res_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      zero_reg  <= zero_next;
      done_reg  <= done_next;
`ifdef ALU_DIV_EN
      dbz_reg   <= dbz_next;
`endif
    end
  end

  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign ALUResult = res_reg;
  assign Zero      = zero_reg;
  assign Hi        = hi_reg;
  assign Lo        = lo_reg;
`ifdef ALU_DIV_EN
  assign div_by_zero = dbz_reg;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_md.sv
// tb_alu_seq_md: directed scenarios plus randomized opcode stream checked
// against an arithmetic reference model of alu_seq_md (WIDTH=32).
module tb_alu_seq_md;
  localparam int W = 32;

  logic          clk;
  logic          reset;
  logic          start;
  logic [3:0]    op_in;
  logic [W-1:0]  a_in, b_in;
  logic [4:0]    sh_in;
  logic          busy, done, zero, dbz;
  logic [W-1:0]  result, hi, lo;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [W-1:0] m_res, m_hi, m_lo;
  logic         m_dbz;
  logic         m_multi;

  alu_seq_md #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUOperation(op_in),
    .A(a_in), .B(b_in), .shamt(sh_in), .busy(busy), .done(done),
    .ALUResult(result), .Zero(zero), .Hi(hi), .Lo(lo), .div_by_zero(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural model: result from plain arithmetic on the opcode's meaning
  task automatic model_op(input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [4:0] sh);
    logic [2*W-1:0] p;
    logic [W-1:0]   t;
    m_multi = 1'b0;
    case (op)
      4'd0:  m_res = a & b;
      4'd1:  m_res = a | b;
      4'd2:  m_res = ~(a | b);
      4'd3:  m_res = a + b;
      4'd4:  m_res = a << sh;
      4'd5:  m_res = a >> sh;
      4'd6:  m_res = $signed(a) >>> sh;
      4'd7:  m_res = a - b;
      4'd8:  begin t = b << (W/2); m_res = t; end
      4'd9:  m_res = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd10: m_res = (a < b) ? 1 : 0;
      4'd11: begin
        p = (2*W)'(a) * (2*W)'(b);
        m_hi = p[2*W-1:W];
        m_lo = p[W-1:0];
        m_res = m_lo;
        m_multi = 1'b1;
      end
      4'd12: begin
`ifdef ALU_DIV_EN
        if (b == 0) begin
          m_lo = '1; m_hi = a; m_dbz = 1'b1;
        end else begin
          m_lo = a / b; m_hi = a % b; m_dbz = 1'b0; m_multi = 1'b1;
        end
        m_res = m_lo;
`else
        m_res = 0;
`endif
      end
      4'd13: m_res = m_hi;
      4'd14: m_res = m_lo;
      default: m_res = 0;
    endcase
  endtask

  task automatic check_outputs();
    check("result", result, m_res);
    check("zero", zero, (m_res == 0));
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    check("dbz", dbz, m_dbz);
  endtask

  // Issue one op (called #1 after an edge); poke<W-1 fires an AND start mid-run
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [4:0] sh, input int poke);
    logic [W-1:0] old_hi, old_lo;
    old_hi = m_hi;
    old_lo = m_lo;
    model_op(op, a, b, sh);
    op_in = op; a_in = a; b_in = b; sh_in = sh; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (m_multi) begin
      for (int i = 0; i < W; i++) begin
        check("busy_iter", busy, 1'b1);
        check("done_iter", done, 1'b0);
        check("hi_hold", hi, old_hi);
        check("lo_hold", lo, old_lo);
        if (i == poke && poke < W - 1) begin
          op_in = 4'd0; a_in = $urandom; b_in = $urandom; start = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
      end
    end
    check("busy_end", busy, 1'b0);
    check("done_end", done, 1'b1);
    check_outputs();
    $display("op=%0d A=%h B=%h sh=%0d -> res=%h zero=%0b hi=%h lo=%h dbz=%0b",
             op, a, b, sh, result, zero, hi, lo, dbz);
  endtask

  task automatic check_reset_state();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1'b1);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_dbz", dbz, 1'b0);
  endtask

  initial begin
    logic [3:0] rop;
    logic [W-1:0] ra, rb;
    reset = 1'b1; start = 1'b0; op_in = 0; a_in = 0; b_in = 0; sh_in = 0;
    m_res = 0; m_hi = 0; m_lo = 0; m_dbz = 0; m_multi = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    reset = 1'b0;
    @(posedge clk); #1;

    // ADD overflow wrap, then done must drop on an idle cycle
    run_op(4'd3, 32'h7FFF_FFFF, 32'h1, 0, 99);
    check("add_const", result, 32'h8000_0000);
    @(posedge clk); #1;
    check("done_drop", done, 1'b0);

    run_op(4'd7, 5, 5, 0, 99);
    run_op(4'd6, 32'h8000_0000, 0, 4, 99);
    check("sra_const", result, 32'hF800_0000);
    run_op(4'd9, 32'hFFFF_FFFF, 1, 0, 99);
    run_op(4'd10, 32'hFFFF_FFFF, 1, 0, 99);

    // MULTU with an ignored start mid-run
    run_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 10);
    check("mul_hi_const", hi, 32'hFFFF_FFFE);

    run_op(4'd12, 100, 7, 0, 99);
    run_op(4'd12, 9, 0, 0, 99);

    // MFLO issued in the done cycle of MULTU, then MFHI
    run_op(4'd11, 3, 4, 0, 99);
    run_op(4'd14, 0, 0, 0, 99);
    run_op(4'd13, 0, 0, 0, 99);

    // Reset during an iterative op aborts it without done
`ifdef ALU_DIV_EN
    op_in = 4'd12;
`else
    op_in = 4'd11;
`endif
    a_in = 1000; b_in = 3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("abort_busy", busy, 1'b1);
      check("abort_done", done, 1'b0);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_state();
    m_hi = 0; m_lo = 0; m_dbz = 0;
    @(posedge clk); #1;
    check("post_rst_done", done, 1'b0);
    run_op(4'd3, 1, 2, 0, 99);
    check("add_after_rst", result, 3);

    // Randomized back-to-back stream
    for (int n = 0; n < 80; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'hFF;
      run_op(rop, ra, rb, 5'($urandom_range(0, 31)), int'($urandom_range(0, 45)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
